// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite-RAM read port; tagged read data returns 1+RAM_LATENCY cycles after accept.
// Optional `SPRITE_ARB_PLAYER_PRIO_EN: requester 0 always wins and does not advance the round-robin pointer.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 24,
  parameter int RAM_LATENCY = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_tag_pipe [0:RAM_LATENCY];
  logic [NUM_REQ-1:0] r_rvalid;
  logic [DATA_W-1:0]  r_rdata;
  logic [ADDR_W-1:0]  r_mem_addr;

  logic [NUM_REQ-1:0] w_rr_req;
  logic               w_prio_hit;
  logic               w_found;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_accept;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [ADDR_W-1:0]  w_sel_addr;

`ifdef SPRITE_ARB_PLAYER_PRIO_EN
  // Player bypasses the rotation; the others rotate among themselves.
  assign w_rr_req   = {req[NUM_REQ-1:1], 1'b0};
  assign w_prio_hit = req[0];
`else
  assign w_rr_req   = req;
  assign w_prio_hit = 1'b0;
`endif

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    if (!Reset && en) begin
      if (w_prio_hit) begin
        w_found   = 1'b1;
        w_gnt_idx = '0;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!w_found && w_rr_req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_found   = 1'b1;
            w_gnt_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
          end
        end
      end
      if (w_found) w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign w_accept   = |(req & w_gnt);
  assign w_sel_addr = addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];

  always_comb begin
    w_next_ptr = r_rr_ptr;
    if (w_accept && !w_prio_hit) begin
      if (int'(w_gnt_idx) == NUM_REQ - 1) w_next_ptr = '0;
      else                                w_next_ptr = w_gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rr_ptr   <= '0;
      r_mem_addr <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      for (int k = 0; k <= RAM_LATENCY; k++) r_tag_pipe[k] <= '0;
    end else begin
      r_rr_ptr      <= w_next_ptr;
      if (w_accept) r_mem_addr <= w_sel_addr;
      r_tag_pipe[0] <= w_accept ? w_gnt : '0;
      for (int k = 1; k <= RAM_LATENCY; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
      // Last tag stage lines up with the RAM output for that read.
      r_rvalid <= r_tag_pipe[RAM_LATENCY];
      if (|r_tag_pipe[RAM_LATENCY]) r_rdata <= mem_data;
    end
  end

  assign gnt      = w_gnt;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed + random bench for sprite_rom_arbiter with a behavioural RAM and a return-order scoreboard.
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(1)) dut (
    .Clk(clk), .Reset(rst), .en(en), .req(req), .addr(addr), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h3C, a[18:3]};
  endfunction

  always @(posedge clk) mem_data <= ram_f(mem_addr);

  typedef struct packed {
    logic [31:0]   due;
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            m_rr = 0;
  logic [AW-1:0] m_maddr = '0;
  logic          rdata_zero = 1'b1;
  logic          hold_addr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_gnt(input logic r, input logic e,
                                              input logic [N-1:0] q, input int ptr);
    logic [N-1:0] one;
    one = 1;
    if (r || !e) return '0;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
    if (q[0]) return one;
    q[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++)
      if (q[(ptr + k) % N]) return one << ((ptr + k) % N);
    return '0;
  endfunction

  task automatic step(input logic r, input logic e, input logic [N-1:0] q, input string nm);
    logic [N-1:0] eg;
    exp_t         x;
    int           gi;
    rst = r;
    en  = e;
    req = q;
    if (!hold_addr)
      for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'($urandom);
    #3;
    eg = model_gnt(r, e, q, m_rr);
    chk({nm, "/gnt"}, 32'(gnt), 32'(eg));
    if (sb.size() > 0 && sb[0].due == 32'(cyc)) begin
      x = sb.pop_front();
      chk({nm, "/rvalid"}, 32'(rvalid), 32'(x.tag));
      chk({nm, "/rdata"}, 32'(rdata), 32'(x.data));
      rdata_zero = 1'b0;
    end else begin
      chk({nm, "/rvalid_idle"}, 32'(rvalid), 32'(0));
      if (rdata_zero) chk({nm, "/rdata_rst"}, 32'(rdata), 32'(0));
    end
    chk({nm, "/mem_addr"}, 32'(mem_addr), 32'(m_maddr));
    if (r) begin
      m_rr = 0;
      m_maddr = '0;
      sb.delete();
      rdata_zero = 1'b1;
    end else if (eg != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (eg[i]) gi = i;
      m_maddr = addr[gi*AW +: AW];
      sb.push_back({32'(cyc + 3), eg, ram_f(m_maddr)});
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
      if (gi != 0) m_rr = (gi + 1) % N;
`else
      m_rr = (gi + 1) % N;
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    req  = '1;
    addr = '0;
    @(posedge clk);
    #1;

    repeat (3) step(1'b1, 1'b1, 4'b1111, "t1_rst");
    step(1'b0, 1'b1, 4'b1111, "t1_first");

    step(1'b1, 1'b1, 4'b0000, "t2_rst");
    hold_addr = 1'b1;
    addr = '0;
    addr[2*AW +: AW] = 19'h00123;
    repeat (6) step(1'b0, 1'b1, 4'b0100, "t2_single");
    chk("t2_mem_addr_const", 32'(mem_addr), 32'h00123);
    hold_addr = 1'b0;
    repeat (3) step(1'b0, 1'b1, 4'b0000, "t2_drain");

    step(1'b1, 1'b1, 4'b0000, "t3_rst");
    repeat (8) step(1'b0, 1'b1, 4'b1111, "t3_all");

    step(1'b0, 1'b1, 4'b1111, "t4_last_acc");
    repeat (5) step(1'b0, 1'b0, 4'b1111, "t4_en0");

    step(1'b0, 1'b1, 4'b0010, "t5_acc");
    step(1'b1, 1'b1, 4'b0000, "t5_rst");
    repeat (4) step(1'b0, 1'b1, 4'b1111, "t5_after");

    repeat (4) step(1'b0, 1'b1, 4'b1111, "t6_all");
    repeat (5) step(1'b0, 1'b1, 4'b1110, "t6_no0");

    repeat (30) step(1'b0, $urandom_range(0, 3) != 0, 4'($urandom), "rand");

    repeat (4) step(1'b0, 1'b1, 4'b0000, "drain");
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
